// File: rtl/demux_stream_router.sv
// rtl/demux_stream_router.sv - registered 1-to-N stream demux with per-channel output registers
// Optional packet mode locks the destination from the first beat until the last beat.
module demux_stream_router #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int SEL_W       = 2,
  parameter int PACKET_MODE = 0,
  parameter int CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_last,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CNT_W-1:0]          drop_cnt
);

  localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(CHANNELS);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    lock_sel_q, lock_sel_d;
  logic [SEL_W-1:0]    eff_sel;
  logic                in_range;
  logic                ch_ready;
  logic                accept;
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] load;
  logic [CHANNELS-1:0] valid_q;
  logic [WIDTH-1:0]    data_q [CHANNELS];
  logic [CNT_W-1:0]    drop_q;

  // Ready is a function of the effective select and channel state only, never of in_valid.
  always_comb begin
    eff_sel  = ((PACKET_MODE != 0) && (state_q == LOCKED)) ? lock_sel_q : in_sel;
    in_range = ({1'b0, eff_sel} < CH_LIM);
    for (int k = 0; k < CHANNELS; k++) begin
      hit[k] = (eff_sel == SEL_W'(k));
    end
    ch_ready = |(hit & (~valid_q | out_ready));
    in_ready = in_range ? ch_ready : 1'b1;
    accept   = in_valid && in_ready;
    load     = accept ? hit : '0;
  end

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    if ((PACKET_MODE != 0) && accept) begin
      case (state_q)
        IDLE: begin
          if (!in_last) begin
            state_d    = LOCKED;
            lock_sel_d = in_sel;
          end
        end
        LOCKED: begin
          if (in_last) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  // A load wins over a drain, so a simultaneous drain and refill keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (load[k]) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= in_data;
        end else if (out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (accept && !in_range && (drop_q != {CNT_W{1'b1}})) begin
      drop_q <= drop_q + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign out_data[g*WIDTH +: WIDTH] = data_q[g];
  end

  assign out_valid = valid_q;
  assign drop_cnt  = drop_q;

endmodule
